// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the IF -> IF/ID -> ID -> ID/EX -> EX pipeline.
// Control outputs are combinational from state and inputs; state and the lost-cycle counter are registered.
module pipeline_hazard_ctrl #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned FETCH_LAT = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              sys_clk_i,
  input  logic              rst_n_i,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              div_busy_i,
  output logic              pc_load_o,
  output logic [ADDR_W-1:0] pc_load_addr_o,
  output logic              pc_hold_o,
  output logic              if_id_hold_o,
  output logic              if_id_flush_o,
  output logic              id_ex_hold_o,
  output logic              id_ex_flush_o,
  output logic [CNT_W-1:0]  lost_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LU_BUBBLE = 2'd1,
    ST_FLUSH     = 2'd2
  } state_t;

  localparam logic [2:0]       FLUSH_INIT_C = 3'(FETCH_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX_C    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             state_next_s;
  logic [2:0]         flush_cnt_r;
  logic [2:0]         flush_cnt_next_s;
  logic [CNT_W-1:0]   lost_cnt_r;

  logic               pc_load_s;
  logic [ADDR_W-1:0]  pc_load_addr_s;
  logic               pc_hold_s;
  logic               if_id_hold_s;
  logic               if_id_flush_s;
  logic               id_ex_hold_s;
  logic               id_ex_flush_s;
  logic               lost_cycle_s;

  // Next-state and control decode; priority is jump, then divider, then load-use.
  always_comb begin
    state_next_s     = state_r;
    flush_cnt_next_s = flush_cnt_r;
    pc_load_s        = 1'b0;
    pc_load_addr_s   = {ADDR_W{1'b0}};
    pc_hold_s        = 1'b0;
    if_id_hold_s     = 1'b0;
    if_id_flush_s    = 1'b0;
    id_ex_hold_s     = 1'b0;
    id_ex_flush_s    = 1'b0;

    if (!rst_n_i) begin
      // Outputs forced quiet while reset is asserted, whatever the inputs do.
      state_next_s     = ST_RUN;
      flush_cnt_next_s = 3'd0;
    end else if (jump_en_i) begin
      pc_load_s      = 1'b1;
      pc_load_addr_s = jump_addr_i;
      if_id_flush_s  = 1'b1;
      id_ex_flush_s  = 1'b1;
      if (FLUSH_INIT_C == 3'd0) begin
        state_next_s     = ST_RUN;
        flush_cnt_next_s = 3'd0;
      end else begin
        state_next_s     = ST_FLUSH;
        flush_cnt_next_s = FLUSH_INIT_C;
      end
    end else begin
      case (state_r)
        ST_FLUSH: begin
          // Fetch-latency slots are squashed even while EX stalls; flush beats hold on IF/ID.
          if_id_flush_s = 1'b1;
          if (div_busy_i) begin
            pc_hold_s    = 1'b1;
            id_ex_hold_s = 1'b1;
          end else begin
            pc_hold_s    = 1'b0;
            id_ex_hold_s = 1'b0;
          end
          if (flush_cnt_r <= 3'd1) begin
            state_next_s     = ST_RUN;
            flush_cnt_next_s = 3'd0;
          end else begin
            state_next_s     = ST_FLUSH;
            flush_cnt_next_s = flush_cnt_r - 3'd1;
          end
        end
        ST_RUN, ST_LU_BUBBLE: begin
          if (div_busy_i) begin
            pc_hold_s    = 1'b1;
            if_id_hold_s = 1'b1;
            id_ex_hold_s = 1'b1;
            state_next_s = ST_RUN;
          end else if ((state_r == ST_RUN) && load_use_i) begin
            pc_hold_s     = 1'b1;
            if_id_hold_s  = 1'b1;
            id_ex_flush_s = 1'b1;
            state_next_s  = ST_LU_BUBBLE;
          end else begin
            // LU_BUBBLE: the load has left EX, so load_use_i is stale this cycle.
            state_next_s = ST_RUN;
          end
          flush_cnt_next_s = 3'd0;
        end
        default: begin
          state_next_s     = ST_RUN;
          flush_cnt_next_s = 3'd0;
        end
      endcase
    end
  end

  assign lost_cycle_s = pc_hold_s | if_id_flush_s | id_ex_flush_s;

  // State, flush countdown and saturating lost-cycle counter.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r     <= ST_RUN;
      flush_cnt_r <= 3'd0;
      lost_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_next_s;
      flush_cnt_r <= flush_cnt_next_s;
      if (lost_cycle_s && (lost_cnt_r != CNT_MAX_C)) begin
        lost_cnt_r <= lost_cnt_r + CNT_ONE_C;
      end else begin
        lost_cnt_r <= lost_cnt_r;
      end
    end
  end

  assign pc_load_o      = pc_load_s;
  assign pc_load_addr_o = pc_load_addr_s;
  assign pc_hold_o      = pc_hold_s;
  assign if_id_hold_o   = if_id_hold_s;
  assign if_id_flush_o  = if_id_flush_s;
  assign id_ex_hold_o   = id_ex_hold_s;
  assign id_ex_flush_o  = id_ex_flush_s;
  assign lost_cnt_o     = lost_cnt_r;

endmodule
